ndindex_addr: RTL and testbench
===============================

NDINDEX_ADDR -- requirements
Module: ndindex_addr

Interface
REQ-001 Parameter SHALL be WIDTH, default 32, bit width of each N-D index component.
REQ-002 Parameter SHALL be ADDR_WIDTH, default 32, bit width of base, strides and linear address.
REQ-003 Port SHALL be clk  input  1  single clock; all logic on posedge clk.
REQ-004 Port SHALL be rst  input  1  synchronous, active-high reset.
REQ-005 Port SHALL be cfg_we  input  1  load base/strides this cycle.
REQ-006 Port SHALL be cfg_base  input  ADDR_WIDTH  base address.
REQ-007 Port SHALL be cfg_stride_0/1/2  input  ADDR_WIDTH each  stride per dimension.
REQ-008 Port SHALL be cfg_busy  output  1  pipeline holds valid data; cfg_we ignored.
REQ-009 Port SHALL be in_valid  input  1  index tuple present.
REQ-010 Port SHALL be in_ready  output  1  block accepts tuple this cycle.
REQ-011 Port SHALL be ndindex_0/1/2  input  WIDTH each  index components, dimension 0 fastest.
REQ-012 Port SHALL be in_last  input  1  final tuple of a sweep.
REQ-013 Port SHALL be out_valid  output  1  linear address valid.
REQ-014 Port SHALL be out_ready  input  1  consumer accepts address.
REQ-015 Port SHALL be addr  output  ADDR_WIDTH  linear address.
REQ-016 Port SHALL be out_last  output  1  in_last delayed with its tuple.
REQ-017 Port SHALL be addr_count  output  ADDR_WIDTH  number of addresses handed off since reset.

Function
REQ-018 addr SHALL equal cfg_base + ndindex_0*stride_0 + ndindex_1*stride_1 + ndindex_2*stride_2, modulo 2^ADDR_WIDTH.
- Indexes zero-extended or truncated to ADDR_WIDTH.
- Products and sums keep only the low ADDR_WIDTH bits.
- Wrap-around is silent.
REQ-019 Pipeline SHALL have 2 register stages:
- S1 registers the three products, the base and last.
- S2 registers the sum and last.
REQ-020 Global advance SHALL be adv = !out_valid || out_ready, with in_ready = adv.
REQ-021 A tuple accepted at edge k SHALL appear with out_valid=1 after edge k+2 if adv holds; throughput SHALL be 1 tuple/cycle.
REQ-022 When out_valid=1 and out_ready=0, addr, out_last and out_valid SHALL hold stable; S1 SHALL hold; no tuple is lost or duplicated.
REQ-023 An S1 bubble SHALL propagate as out_valid=0; valid bits SHALL advance only on adv.
REQ-024 cfg_busy SHALL be 1 when S1 or S2 holds a valid entry.
REQ-025 Configuration load:
- When cfg_we=1 and cfg_busy=0, base and strides SHALL register at that edge.
- They apply to tuples accepted from the next edge on.
- cfg_we=1 while cfg_busy=1 SHALL be ignored.
REQ-026 If cfg_we=1 and in_valid=1 in the same idle cycle, the tuple SHALL use the old configuration.
REQ-027 addr_count SHALL increment by 1 on each cycle with out_valid && out_ready and wrap from all-ones to 0.

Reset
REQ-028 When rst=1 at a posedge, the following SHALL clear to 0 regardless of other inputs, with in-flight tuples discarded:
- S1/S2 valid bits
- out_valid, addr, out_last
- addr_count
- base and strides
REQ-029 in_ready SHALL be 1 and cfg_busy 0 in the first cycle after reset.

Structure
REQ-030 A shared package SHALL hold:
- the dimension count constant NDIM=3
- default WIDTH/ADDR_WIDTH constants
- the config record type (base plus stride array)
REQ-031 One sub-module ndindex_addr_mac (registered multiply by stride, one per dimension) SHALL be instantiated NDIM times; the remainder is flat.

Verification
REQ-032 Basic computation: cfg base=0x1000, strides 1/10/100 -> tuple (3,4,5) -> addr=0x121F two cycles after acceptance.
REQ-033 Streaming: out_ready=1, 8 back-to-back tuples -> 8 consecutive out_valid cycles in order, addr_count=8.
REQ-034 Backpressure: out_ready=0 for 5 cycles mid-stream -> addr held, in_ready=0 after pipeline fills, no loss or duplication on release.
REQ-035 Wrap: base=0xFFFFFFFF, stride_0=1, tuple (1,0,0) -> addr=0x00000000.
REQ-036 Configuration gating: cfg_we with a new base while cfg_busy=1 -> ignored. After drain, cfg_we -> next tuple uses the new base. out_last tracks in_last.
REQ-037 Reset mid-stream: rst with 2 entries in flight -> next cycle out_valid=0, addr_count=0, in_ready=1, no stale output.

Source files
------------

// File: rtl/ndindex_addr_pkg.sv
// Shared constants and the configuration record for the N-D index to linear address block.
// The config record is sized to DEF_ADDR_WIDTH; instances must keep ADDR_WIDTH <= DEF_ADDR_WIDTH.
package ndindex_addr_pkg;

  localparam int NDIM           = 3;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]           base;
    logic [NDIM-1:0][DEF_ADDR_WIDTH-1:0] stride;
  } cfg_t;

endpackage

// File: rtl/ndindex_addr_mac.sv
// One dimension's index times stride, registered; low ADDR_WIDTH bits kept, holds when en=0.
module ndindex_addr_mac
  import ndindex_addr_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      idx,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic [ADDR_WIDTH-1:0] prod
);

  // Index is zero-extended or truncated to the address width before multiplying.
  logic [ADDR_WIDTH-1:0] idx_ext;
  assign idx_ext = ADDR_WIDTH'(idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
    end else if (en) begin
      prod <= idx_ext * stride;
    end
  end

endmodule

// File: rtl/ndindex_addr.sv
// Two-stage pipeline mapping an (i0,i1,i2) tuple to base + sum(i*stride) modulo 2^ADDR_WIDTH.
// Single global advance: both stages move only when the output slot is empty or being taken.
module ndindex_addr
  import ndindex_addr_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_0,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_1,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_2,
  output logic                  cfg_busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      ndindex_0,
  input  logic [WIDTH-1:0]      ndindex_1,
  input  logic [WIDTH-1:0]      ndindex_2,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] addr_count
);

  cfg_t                  cfg_q;
  logic                  adv;
  logic                  s1_vld;
  logic                  s1_last;
  logic [ADDR_WIDTH-1:0] s1_base;
  logic [WIDTH-1:0]      idx  [NDIM];
  logic [ADDR_WIDTH-1:0] prod [NDIM];

  assign idx[0] = ndindex_0;
  assign idx[1] = ndindex_1;
  assign idx[2] = ndindex_2;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign cfg_busy = s1_vld || out_valid;

  // Config only changes with an empty pipeline, so in-flight tuples never mix configurations.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
    end else if (cfg_we && !cfg_busy) begin
      cfg_q.base      <= DEF_ADDR_WIDTH'(cfg_base);
      cfg_q.stride[0] <= DEF_ADDR_WIDTH'(cfg_stride_0);
      cfg_q.stride[1] <= DEF_ADDR_WIDTH'(cfg_stride_1);
      cfg_q.stride[2] <= DEF_ADDR_WIDTH'(cfg_stride_2);
    end
  end

  for (genvar d = 0; d < NDIM; d++) begin : g_mac
    ndindex_addr_mac #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .en     (adv),
      .idx    (idx[d]),
      .stride (ADDR_WIDTH'(cfg_q.stride[d])),
      .prod   (prod[d])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_base <= '0;
    end else if (adv) begin
      s1_vld  <= in_valid;
      s1_last <= in_last;
      s1_base <= ADDR_WIDTH'(cfg_q.base);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      addr      <= '0;
    end else if (adv) begin
      out_valid <= s1_vld;
      out_last  <= s1_last;
      addr      <= s1_base + prod[0] + prod[1] + prod[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_count <= '0;
    end else if (out_valid && out_ready) begin
      addr_count <= addr_count + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ndindex_addr.sv
// Randomized bench: a queue-based reference of accepted tuples is checked every cycle,
// plus directed cases with hand-computed addresses.
module tb_ndindex_addr;

  logic        clk = 1'b0;
  logic        rst, cfg_we, cfg_busy, in_valid, in_ready, in_last;
  logic        out_valid, out_ready, out_last;
  logic [31:0] cfg_base, cfg_stride_0, cfg_stride_1, cfg_stride_2;
  logic [31:0] ndindex_0, ndindex_1, ndindex_2;
  logic [31:0] addr, addr_count;

  ndindex_addr #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_base(cfg_base),
    .cfg_stride_0(cfg_stride_0), .cfg_stride_1(cfg_stride_1), .cfg_stride_2(cfg_stride_2),
    .cfg_busy(cfg_busy), .in_valid(in_valid), .in_ready(in_ready),
    .ndindex_0(ndindex_0), .ndindex_1(ndindex_1), .ndindex_2(ndindex_2),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .addr(addr), .out_last(out_last), .addr_count(addr_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] calc(input logic [31:0] b, s0, s1, s2, i0, i1, i2);
    return b + i0 * s0 + i1 * s1 + i2 * s2;
  endfunction

  // Reference: every accepted, not yet handed-off tuple is in flight; it becomes
  // visible two edges after acceptance once it reaches the head of the queue.
  typedef struct {
    logic [31:0] a;
    logic        l;
    int          acc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_base, m_s0, m_s1, m_s2, m_cnt;
  logic        mon_on = 1'b0;
  logic        exp_ov, m_busy;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    exp_ov = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
    if (mon_on) begin
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("addr", addr, q[0].a);
        chk("out_last", out_last, q[0].l);
      end
      chk("cfg_busy", cfg_busy, q.size() != 0);
      chk("in_ready", in_ready, !exp_ov || out_ready);
      chk("addr_count", addr_count, m_cnt);
    end
    if (rst) begin
      q.delete();
      m_cnt  = '0;
      m_base = '0; m_s0 = '0; m_s1 = '0; m_s2 = '0;
    end else begin
      m_busy = q.size() != 0;
      if (exp_ov && out_ready) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (in_valid && (!exp_ov || out_ready))
        q.push_back('{calc(m_base, m_s0, m_s1, m_s2, ndindex_0, ndindex_1, ndindex_2), in_last, cyc});
      if (cfg_we && !m_busy) begin
        m_base = cfg_base; m_s0 = cfg_stride_0; m_s1 = cfg_stride_1; m_s2 = cfg_stride_2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_tuple();
    case ($urandom_range(0, 2))
      0: begin ndindex_0 = $urandom_range(0, 15); ndindex_1 = $urandom_range(0, 15); ndindex_2 = $urandom_range(0, 15); end
      1: begin ndindex_0 = $urandom_range(0, 4095); ndindex_1 = $urandom_range(0, 255); ndindex_2 = $urandom_range(0, 31); end
      default: begin ndindex_0 = $urandom; ndindex_1 = $urandom; ndindex_2 = $urandom; end
    endcase
    in_last = $urandom_range(0, 1);
  endtask

  task automatic load_cfg(input logic [31:0] b, s0, s1, s2);
    cfg_we = 1'b1; cfg_base = b; cfg_stride_0 = s0; cfg_stride_1 = s1; cfg_stride_2 = s2;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!cfg_busy && !out_valid) break;
      tick();
    end
    chk("drain_timeout", cfg_busy || out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int          ov_cnt;
  logic        acc;
  logic [31:0] held;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    cfg_base = '0; cfg_stride_0 = '0; cfg_stride_1 = '0; cfg_stride_2 = '0;
    ndindex_0 = '0; ndindex_1 = '0; ndindex_2 = '0;
    tick(); tick();
    rst = 1'b0; mon_on = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_cfg_busy", cfg_busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_addr_count", addr_count, 32'h0);
    tick();

    // Basic computation: 0x1000 + 3 + 40 + 500 = 0x121F
    load_cfg(32'h1000, 32'd1, 32'd10, 32'd100);
    out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    ndindex_0 = 32'd3; ndindex_1 = 32'd4; ndindex_2 = 32'd5;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("basic_lat1_valid", out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_addr", addr, 32'h121F);
    chk("basic_last", out_last, 1'b1);
    tick();
    drain();

    // Streaming: 8 back-to-back tuples after a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    load_cfg($urandom, $urandom_range(1, 64), $urandom_range(1, 4096), $urandom);
    out_ready = 1'b1; ov_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 8);
      rand_tuple();
      @(negedge clk);
      if (out_valid) ov_cnt++;
      tick();
    end
    chk("stream_valid_cycles", ov_cnt, 8);
    chk("stream_addr_count", addr_count, 32'd8);

    // Backpressure: consumer stalls for 5 cycles mid-stream
    load_cfg($urandom, $urandom, $urandom, $urandom);
    in_valid = 1'b1; rand_tuple(); held = '0;
    for (int i = 0; i < 18; i++) begin
      out_ready = !(i >= 5 && i < 10);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (i == 5) held = addr;
      if (i == 9) begin
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_addr_held", addr, held);
      end
      tick();
      if (acc) rand_tuple();
    end
    drain();

    // Wrap: 0xFFFFFFFF + 1*1 = 0
    load_cfg(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    in_valid = 1'b1; in_last = 1'b0;
    ndindex_0 = 32'd1; ndindex_1 = 32'd0; ndindex_2 = 32'd0;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("wrap_valid", out_valid, 1'b1);
    chk("wrap_addr", addr, 32'h0);
    tick();

    // Config gating: a write while busy is dropped
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_tuple();
      cfg_we = (i == 1); cfg_base = 32'hABC0; cfg_stride_0 = 32'd7;
      tick();
    end
    cfg_we = 1'b0;
    drain();
    // Load with a tuple in the same idle cycle: that tuple uses old config (0xFFFFFFFF + 2 = 1)
    cfg_we = 1'b1; cfg_base = 32'h5000; cfg_stride_0 = 32'd4; cfg_stride_1 = 32'd0; cfg_stride_2 = 32'd0;
    in_valid = 1'b1; in_last = 1'b0; ndindex_0 = 32'd2;
    tick();
    cfg_we = 1'b0; in_last = 1'b1; ndindex_0 = 32'd3;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("cfg_old_addr", addr, 32'h1);
    chk("cfg_old_last", out_last, 1'b0);
    tick();
    @(negedge clk);
    chk("cfg_new_addr", addr, 32'h500C);
    chk("cfg_new_last", out_last, 1'b1);
    tick();

    // Random traffic with occasional resets and config writes
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_base  = $urandom; cfg_stride_0 = $urandom_range(0, 1024);
      cfg_stride_1 = $urandom; cfg_stride_2 = $urandom_range(0, 3) << 20;
      in_valid  = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      rand_tuple();
      tick();
    end
    rst = 1'b0; cfg_we = 1'b0;
    drain();

    // Reset mid-stream with two entries in flight
    in_valid = 1'b1; rand_tuple(); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_tuple(); tick();
    rand_tuple(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_addr_count", addr_count, 32'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_cfg_busy", cfg_busy, 1'b0);
    tick();
    tick();
    @(negedge clk);
    chk("midrst_no_stale", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
